// File: rtl/dds_sched_pkg.sv
//============================================================================
// Module      : dds_sched_pkg
// Description : Shared types and constants for the DDS phase scheduler.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package dds_sched_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } sched_state_t;

    // Step-pattern modes
    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_CONT     = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    // Phase_cntrl select width and its highest code
    localparam int               STEP_W   = 2;
    localparam logic [STEP_W-1:0] STEP_MAX = 2'd3;

endpackage : dds_sched_pkg

`default_nettype wire

// File: rtl/dds_wrap_detect.sv
//============================================================================
// Module      : dds_wrap_detect
// Description : Flags a DDS phase-accumulator wrap-around, i.e. the cycle in
//               which the presented accumulator value is smaller than the
//               value seen one cycle earlier.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module dds_wrap_detect
    import dds_sched_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,      // synchronous, active-low
    input  logic [ACC_W-1:0] acc_in,
    output logic             wrap
);

    logic [ACC_W-1:0] acc_prev_q;
    logic             prev_valid_q;

    // Previous accumulator sample; the comparison is only trusted once a
    // real sample has been captured after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_prev_q   <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            acc_prev_q   <= acc_in;
            prev_valid_q <= 1'b1;
        end
    end

    assign wrap = prev_valid_q && (acc_in < acc_prev_q);

endmodule : dds_wrap_detect

`default_nettype wire

// File: rtl/dds_phase_scheduler.sv
//============================================================================
// Module      : dds_phase_scheduler
// Description : Steps the DDS Phase_cntrl select through a programmed
//               pattern (one-shot, continuous, ping-pong or hold) with a
//               programmable dwell per step.
//               Build option DDS_SCHED_WRAP_SYNC_EN: when defined, steps
//               change on accumulator wrap-around and dwell counts wraps;
//               when undefined, acc_in is ignored and dwell counts clocks.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module dds_phase_scheduler
    import dds_sched_pkg::*;
#(
    parameter int ACC_W   = 8,
    parameter int DWELL_W = 16,
    parameter int NSTEP   = 4
) (
    input  logic               clk,
    input  logic               rst,          // synchronous, active-low
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [1:0]         cfg_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [ACC_W-1:0]   acc_in,
    output logic [STEP_W-1:0]  Phase_cntrl,
    output logic               busy,
    output logic               done,
    output logic               step_strobe
);

    // NSTEP is tied to the 2-bit select; anything outside 1..4 falls back to
    // the full code range.
    localparam logic [STEP_W-1:0]  c_step_last = (NSTEP >= 1 && NSTEP <= 4) ?
                                                 STEP_W'(NSTEP - 1) : STEP_MAX;
    localparam logic [STEP_W-1:0]  c_step_one  = STEP_W'(1);
    localparam logic [DWELL_W-1:0] c_dwell_one = DWELL_W'(1);

    logic w_wrap;

`ifdef DDS_SCHED_WRAP_SYNC_EN
    dds_wrap_detect #(
        .ACC_W  (ACC_W)
    ) u_wrap_detect (
        .clk    (clk),
        .rst    (rst),
        .acc_in (acc_in),
        .wrap   (w_wrap)
    );
`else
    // Free-running: every clock behaves as a wrap; the accumulator is unused.
    logic w_unused_acc;
    assign w_unused_acc = ^acc_in;
    assign w_wrap       = 1'b1;
`endif

    sched_state_t         state_q, state_d;
    logic [STEP_W-1:0]    phase_q, phase_d;
    logic [DWELL_W-1:0]   count_q, count_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;      // effective dwell, never 0
    logic [1:0]           mode_q,  mode_d;
    logic [1:0]           cfg_q,   cfg_d;
    logic                 dir_q,   dir_d;        // 0 = up, 1 = down
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;
    logic                 strobe_q, strobe_d;

    // State, latched configuration and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            count_q  <= '0;
            dwell_q  <= c_dwell_one;
            mode_q   <= MODE_ONESHOT;
            cfg_q    <= '0;
            dir_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            count_q  <= count_d;
            dwell_q  <= dwell_d;
            mode_q   <= mode_d;
            cfg_q    <= cfg_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            strobe_q <= strobe_d;
        end
    end

    // Next-state, step advance and output pulse generation
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        count_d  = count_q;
        dwell_d  = dwell_q;
        mode_d   = mode_q;
        cfg_d    = cfg_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        strobe_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A coincident stop vetoes the start
                if (start && !stop) begin
                    mode_d  = mode;
                    cfg_d   = cfg_step;
                    dwell_d = (dwell == '0) ? c_dwell_one : dwell;
                    count_d = '0;
                    state_d = ARM;
                end
            end

            ARM: begin
                if (stop) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (w_wrap) begin
                    phase_d  = (mode_q == MODE_HOLD) ? cfg_q : '0;
                    strobe_d = 1'b1;
                    count_d  = '0;
                    dir_d    = 1'b0;
                    state_d  = RUN;
                end
            end

            RUN: begin
                // stop wins over an advance landing on the same edge
                if (stop) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (w_wrap) begin
                    if (count_q == dwell_q - c_dwell_one) begin
                        count_d = '0;
                        unique case (mode_q)
                            MODE_ONESHOT: begin
                                if (phase_q == c_step_last) begin
                                    done_d  = 1'b1;
                                    state_d = IDLE;
                                end else begin
                                    phase_d  = phase_q + c_step_one;
                                    strobe_d = 1'b1;
                                end
                            end
                            MODE_CONT: begin
                                phase_d  = (phase_q == c_step_last) ? '0 :
                                           phase_q + c_step_one;
                                strobe_d = 1'b1;
                            end
                            MODE_PINGPONG: begin
                                // Turn around at the endpoints without
                                // repeating them
                                strobe_d = 1'b1;
                                if (!dir_q) begin
                                    if (phase_q == c_step_last) begin
                                        dir_d   = 1'b1;
                                        phase_d = phase_q - c_step_one;
                                    end else begin
                                        phase_d = phase_q + c_step_one;
                                    end
                                end else begin
                                    if (phase_q == '0) begin
                                        dir_d   = 1'b0;
                                        phase_d = phase_q + c_step_one;
                                    end else begin
                                        phase_d = phase_q - c_step_one;
                                    end
                                end
                            end
                            default: begin
                                // Hold: the dwell count keeps cycling only
                            end
                        endcase
                    end else begin
                        count_d = count_q + c_dwell_one;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign Phase_cntrl = phase_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign step_strobe = strobe_q;

endmodule : dds_phase_scheduler

`default_nettype wire

// File: tb/tb_dds_phase_scheduler.sv
//============================================================================
// Module      : tb_dds_phase_scheduler
// Description : Self-checking bench for dds_phase_scheduler. Accumulator
//               model adds 32 per clock (wrap every 8 clocks). Honours
//               DDS_SCHED_WRAP_SYNC_EN in the same way as the design.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_dds_phase_scheduler;
    import dds_sched_pkg::*;

`ifdef DDS_SCHED_WRAP_SYNC_EN
    localparam int P = 8;       // clocks per dwell unit
`else
    localparam int P = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [1:0]  cfg_step;
    logic [15:0] dwell;
    logic [7:0]  acc_in;
    logic [1:0]  Phase_cntrl;
    logic        busy;
    logic        done;
    logic        step_strobe;

    always #5 clk = ~clk;

    dds_phase_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .cfg_step    (cfg_step),
        .dwell       (dwell),
        .acc_in      (acc_in),
        .Phase_cntrl (Phase_cntrl),
        .busy        (busy),
        .done        (done),
        .step_strobe (step_strobe)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Event recorder
    bit         rec = 1'b0;
    int         s_cnt;
    int         s_cyc [16];
    logic [1:0] s_val [16];
    logic [7:0] s_acc [16];
    int         d_cnt;
    int         d_cyc;
    logic [7:0] d_acc;
    logic [1:0] last_phase;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [15:0] mk_seq(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [15:0] s;
        s = {a7[1:0], a6[1:0], a5[1:0], a4[1:0], a3[1:0], a2[1:0], a1[1:0], a0[1:0]};
        return s;
    endfunction

    task automatic clear_rec();
        s_cnt = 0;
        d_cnt = 0;
        d_cyc = 0;
        d_acc = '0;
    endtask

    // One clock: sample outputs 1 time unit after the edge, check the
    // always-true properties, record events, then advance the accumulator.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            check("strobe_done_exclusive", int'(step_strobe && done), 0);
            if (done) check("busy_low_at_done", int'(busy), 0);
            if (!step_strobe) check("phase_changes_only_with_strobe", int'(Phase_cntrl), int'(last_phase));
            if (rec && step_strobe && s_cnt < 16) begin
                s_cyc[s_cnt] = cyc;
                s_val[s_cnt] = Phase_cntrl;
                s_acc[s_cnt] = acc_in;
                s_cnt++;
            end
            if (rec && done) begin
                d_cnt++;
                d_cyc = cyc;
                d_acc = acc_in;
            end
        end
        last_phase = Phase_cntrl;
        acc_in     = acc_in + 8'd32;
    endtask

    typedef struct packed {
        logic [1:0]  mode;
        logic [1:0]  cfg;
        logic [15:0] dwell;
        logic [15:0] seq;    // expected step codes, entry k at [2k+1:2k]
        int          n;      // number of expected strobes to compare
        int          deff;   // effective dwell
    } vec_t;

    vec_t vecs [5];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [1:0] prev;
        int         found;

        vecs[0] = '{mode: MODE_ONESHOT,  cfg: 2'd0, dwell: 16'd2, seq: mk_seq(0,1,2,3,0,0,0,0), n: 4, deff: 2};
        vecs[1] = '{mode: MODE_PINGPONG, cfg: 2'd0, dwell: 16'd1, seq: mk_seq(0,1,2,3,2,1,0,1), n: 8, deff: 1};
        vecs[2] = '{mode: MODE_CONT,     cfg: 2'd0, dwell: 16'd0, seq: mk_seq(0,1,2,3,0,0,0,0), n: 5, deff: 1};
        vecs[3] = '{mode: MODE_HOLD,     cfg: 2'd2, dwell: 16'd1, seq: mk_seq(2,0,0,0,0,0,0,0), n: 1, deff: 1};
        vecs[4] = '{mode: MODE_CONT,     cfg: 2'd0, dwell: 16'd5, seq: mk_seq(0,1,2,3,0,0,0,0), n: 5, deff: 5};

        rst      = 1'b0;
        start    = 1'b1;
        stop     = 1'b0;
        mode     = 2'b00;
        cfg_step = 2'b00;
        dwell    = 16'd1;
        acc_in   = 8'd0;
        clear_rec();

        // Reset held with start asserted
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("reset%0d_phase", k), int'(Phase_cntrl), 0);
            check($sformatf("reset%0d_busy", k), int'(busy), 0);
            check($sformatf("reset%0d_done", k), int'(done), 0);
        end
        rst   = 1'b1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("post_reset%0d_strobe", k), int'(step_strobe), 0);
            check($sformatf("post_reset%0d_busy", k), int'(busy), 0);
        end

        // Table-driven pattern runs
        for (int i = 0; i < 5; i++) begin
            vec_t v;
            int   w;
            int   lim;
            int   start_cyc;
            v = vecs[i];
            w = 8 + ((v.mode == MODE_HOLD) ? 4 : v.n) * v.deff * P + 4;

            mode     = v.mode;
            cfg_step = v.cfg;
            dwell    = v.dwell;
            clear_rec();
            rec   = 1'b1;
            start = 1'b1;
            tick();
            start_cyc = cyc;
            start     = 1'b0;
            // Config changes after latching must have no effect
            mode     = ~v.mode;
            cfg_step = ~v.cfg;
            dwell    = 16'hFFFF;
            check($sformatf("v%0d_busy_after_start", i), int'(busy), 1);

            for (int t = 1; t < w; t++) begin
                if (v.mode != MODE_ONESHOT && t == w / 2) start = 1'b1;
                tick();
                start = 1'b0;
            end
            rec = 1'b0;

            if (v.mode == MODE_HOLD)
                check($sformatf("v%0d_strobe_count", i), s_cnt, 1);
            else if (v.mode == MODE_ONESHOT)
                check($sformatf("v%0d_strobe_count", i), s_cnt, 4);
            else
                check($sformatf("v%0d_enough_strobes", i), int'(s_cnt >= v.n), 1);

            lim = (s_cnt < v.n) ? s_cnt : v.n;
            for (int k = 0; k < lim; k++)
                check($sformatf("v%0d_step%0d", i, k), int'(s_val[k]), int'(v.seq[2*k +: 2]));
            for (int k = 1; k < lim; k++)
                check($sformatf("v%0d_interval%0d", i, k), s_cyc[k] - s_cyc[k-1], v.deff * P);
`ifdef DDS_SCHED_WRAP_SYNC_EN
            for (int k = 0; k < lim; k++)
                check($sformatf("v%0d_wrap_aligned%0d", i, k), int'(s_acc[k]), 0);
            if (lim > 0)
                check($sformatf("v%0d_arm_latency_in_range", i),
                      int'((s_cyc[0] - start_cyc) >= 1 && (s_cyc[0] - start_cyc) <= 8), 1);
`else
            if (lim > 0)
                check($sformatf("v%0d_arm_latency", i), s_cyc[0] - start_cyc, 1);
`endif

            if (v.mode == MODE_ONESHOT) begin
                check($sformatf("v%0d_done_count", i), d_cnt, 1);
                if (lim > 0)
                    check($sformatf("v%0d_done_delay", i), d_cyc - s_cyc[lim-1], v.deff * P);
`ifdef DDS_SCHED_WRAP_SYNC_EN
                check($sformatf("v%0d_done_wrap_aligned", i), int'(d_acc), 0);
`endif
                check($sformatf("v%0d_final_phase", i), int'(Phase_cntrl), 3);
                check($sformatf("v%0d_final_busy", i), int'(busy), 0);
            end else begin
                check($sformatf("v%0d_no_done", i), d_cnt, 0);
                if (v.mode == MODE_HOLD)
                    check($sformatf("v%0d_hold_phase", i), int'(Phase_cntrl), int'(v.cfg));
                prev = Phase_cntrl;
                stop = 1'b1;
                tick();
                stop = 1'b0;
                check($sformatf("v%0d_stop_busy", i), int'(busy), 0);
                check($sformatf("v%0d_stop_phase", i), int'(Phase_cntrl), int'(prev));
                check($sformatf("v%0d_stop_done", i), int'(done), 0);
            end
        end

        // Stop coincident with the wrap that would advance 1 -> 2
        mode     = MODE_CONT;
        cfg_step = 2'd0;
        dwell    = 16'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int t = 0; t < 200 && found == 0; t++) begin
            tick();
            if (step_strobe && Phase_cntrl == 2'd1) found = 1;
        end
        check("stopprio_reached_step1", found, 1);
        for (int k = 0; k < 3; k++) begin
`ifdef DDS_SCHED_WRAP_SYNC_EN
            while (acc_in != 8'd0) tick();
`endif
            if (k == 2) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        check("stopprio_phase", int'(Phase_cntrl), 1);
        check("stopprio_busy", int'(busy), 0);
        check("stopprio_strobe", int'(step_strobe), 0);
        check("stopprio_done", int'(done), 0);
        clear_rec();
        rec = 1'b1;
        repeat (10) tick();
        rec = 1'b0;
        check("stopprio_phase_holds", int'(Phase_cntrl), 1);
        check("stopprio_no_done_later", d_cnt, 0);

        // start and stop together in IDLE: no sequence begins
        mode  = MODE_CONT;
        dwell = 16'd1;
        start = 1'b1;
        stop  = 1'b1;
        clear_rec();
        rec = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_busy", int'(busy), 0);
        repeat (12) tick();
        rec = 1'b0;
        check("startstop_still_idle", int'(busy), 0);
        check("startstop_no_strobe", s_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dds_phase_scheduler

`default_nettype wire

// File: doc/dds_phase_scheduler.md
Name: dds_phase_scheduler

Overview:
Sequencer for the DDS phase-increment select: drives the DDS Phase_cntrl input through a programmed step pattern with a programmable dwell per step. Step changes land on accumulator wrap-around so the output waveform stays phase-continuous. Sits between the control/test logic and the DDS and monitors the DDS Register_out.

Parameters:
ACC_W, 8, width of the DDS phase accumulator value (Register_out)
DWELL_W, 16, width of the dwell counter and the dwell config input
NSTEP, 4, number of Phase_cntrl codes; fixed by the 2-bit select

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
start  in  1  begin a sequence; sampled only in IDLE
stop  in  1  abort the sequence; sampled in ARM/RUN
mode  in  2  00 one-shot up sweep, 01 continuous up, 10 ping-pong, 11 hold cfg_step
cfg_step  in  2  step code used by mode 11
dwell  in  DWELL_W  wraps (or cycles without the macro) per step; 0 treated as 1
acc_in  in  ACC_W  DDS Register_out
Phase_cntrl  out  2  to DDS Phase_cntrl
busy  out  1  high in ARM and RUN
done  out  1  1-cycle pulse on one-shot completion
step_strobe  out  1  1-cycle pulse, same cycle Phase_cntrl takes a new value

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, Phase_cntrl=0, busy=0, done=0, step_strobe=0, dwell count=0, direction=up, prev_valid=0.
- Wrap detect: acc_prev registers acc_in every cycle. wrap = prev_valid && (acc_in < acc_prev). prev_valid is set 1 cycle after leaving reset.
- All outputs are registered. Phase_cntrl changes at the edge that samples wrap, so it is visible 1 cycle after the wrapped acc_in is presented.
- IDLE: Phase_cntrl holds its last value. On start && !stop: latch mode, cfg_step, and dwell_eff=max(dwell,1); go to ARM. If start and stop are both high in IDLE, start is ignored.
- ARM: on the first wrap, load Phase_cntrl with the initial step (cfg_step for mode 11, else 0), pulse step_strobe, clear the count, set direction=up, go to RUN.
- RUN, on each wrap: if count==dwell_eff-1, advance and clear the count; otherwise count+1. No wrap means no change.
- Advance rules:
  - mode 00: step 0->1->2->3. When dwell completes at step 3, go to IDLE, pulse done, hold Phase_cntrl=3, no step_strobe.
  - mode 01: 0->1->2->3->0, continuous.
  - mode 10: 0,1,2,3,2,1,0,1,... The direction flips at 3 and at 0; endpoints are not repeated.
  - mode 11: never advances. The count still runs and step_strobe is not pulsed after ARM.
- stop in ARM or RUN: go to IDLE on the next edge. Phase_cntrl holds, no done pulse, count cleared. stop has priority over a coincident wrap advance.
- start while busy: ignored. Config inputs are ignored after latching.
- done and step_strobe are never high in the same cycle. busy falls in the same cycle done pulses.
- Reset mid-sequence returns everything to the reset values above; the sequence is not resumed.

Optional Feature:
DDS_SCHED_WRAP_SYNC_EN
- Defined: behaviour as above. Step changes are wrap-aligned and dwell counts accumulator wraps.
- Undefined: acc_in is ignored and treated as wrap=1 every cycle. ARM lasts exactly 1 cycle. dwell counts clk cycles, and steps change without phase alignment.

Decomposition:
- Package dds_sched_pkg holds:
  - state enum {IDLE, ARM, RUN}
  - mode constants MODE_ONESHOT=2'b00, MODE_CONT=2'b01, MODE_PINGPONG=2'b10, MODE_HOLD=2'b11
  - STEP_W=2 and STEP_MAX=2'd3
- One sub-module, dds_wrap_detect: acc_prev register, prev_valid, and the wrap output. It is bypassed when the macro is undefined.

Test Plan:
- Setup for all scenarios: the bench accumulator model adds 32 per cycle (ACC_W=8), so a wrap occurs every 8 cycles. Macro defined unless stated.
- Reset: hold rst=0 for 3 cycles with start=1 -> Phase_cntrl=0, busy=0, done=0 throughout. After release, 2 idle cycles -> no step_strobe.
- One-shot: mode=00, dwell=2, start pulse -> busy=1. The step sequence 0,1,2,3 changes only 1 cycle after each wrap, with each step lasting 16 cycles. A single done pulse follows, then Phase_cntrl stays 3 and busy=0.
- Ping-pong: mode=10, dwell=1 -> Phase_cntrl follows 0,1,2,3,2,1,0,1 with one step_strobe per change and 8 cycles between strobes.
- Stop/priority:
  - mode=01, dwell=3; assert stop on the same cycle as the wrap that would advance 1->2 -> Phase_cntrl stays 1, busy=0 next cycle, no done pulse.
  - Start+stop together in IDLE -> stays IDLE.
- Edge cases:
  - dwell=0 behaves as dwell=1.
  - mode=11, cfg_step=2 -> Phase_cntrl=2 after the first wrap, with exactly one step_strobe.
  - Macro undefined, mode=01, dwell=5 -> Phase_cntrl steps every 5 cycles regardless of acc_in.
